// File: rtl/control_unit_if.sv
// Host/datapath bundle for the process-in-memory control unit.
// master: the control unit itself; slave: the host plus memory/ALU datapath.
interface control_unit_if;
  logic [44:0] instruction;
  logic        mem_ready;
  logic        operation_enable;
  logic [31:0] immediate_memory_data;
  logic        memory_write;
  logic        memory_read;
  logic        mux_select;
  logic [9:0]  memory_address;
  logic        reg_select;
  logic        reg_load_enable;
  logic [1:0]  alu_opcode;
  logic        ready;

  modport master (
    input  instruction,
    input  mem_ready,
    input  operation_enable,
    output immediate_memory_data,
    output memory_write,
    output memory_read,
    output mux_select,
    output memory_address,
    output reg_select,
    output reg_load_enable,
    output alu_opcode,
    output ready
  );

  modport slave (
    output instruction,
    output mem_ready,
    output operation_enable,
    input  immediate_memory_data,
    input  memory_write,
    input  memory_read,
    input  mux_select,
    input  memory_address,
    input  reg_select,
    input  reg_load_enable,
    input  alu_opcode,
    input  ready
  );
endinterface

// File: rtl/control_unit.sv
// Sequencer for the process-in-memory datapath: decodes a 45-bit instruction and
// drives the word-memory handshake, operand-register loads, ALU opcode and write mux.
// All outputs are registered (Moore).
// Optional: define CU_MEM_TIMEOUT_EN to abandon a memory access that has not seen
// mem_ready within TIMEOUT_CYCLES cycles (FSM then goes straight to StDone).
module control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    StIdle,
    StRd,
    StWr,
    StARd1,
    StALd1,
    StARd2,
    StALd2,
    StAWr,
    StDone
  } state_t;

  state_t     state_q;
  logic       en_q;
  logic [9:0] src2_q;
  logic [9:0] dst_q;
  logic       timeout_hit;

`ifdef CU_MEM_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] tmo_q;

  // Cycles the current strobe has waited; cleared whenever no request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (!(bus.memory_read || bus.memory_write) || bus.mem_ready) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout_hit = (bus.memory_read || bus.memory_write) &&
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Sequencer: state and every output register are updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                   <= StIdle;
      en_q                      <= 1'b0;
      src2_q                    <= '0;
      dst_q                     <= '0;
      bus.immediate_memory_data <= '0;
      bus.memory_write          <= 1'b0;
      bus.memory_read           <= 1'b0;
      bus.mux_select            <= 1'b0;
      bus.memory_address        <= '0;
      bus.reg_select            <= 1'b0;
      bus.reg_load_enable       <= 1'b0;
      bus.alu_opcode            <= '0;
      bus.ready                 <= 1'b1;
    end else begin
      en_q                <= bus.operation_enable;
      // Load pulse lasts exactly one cycle.
      bus.reg_load_enable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.operation_enable && !en_q) begin
            bus.ready <= 1'b0;
            src2_q    <= bus.instruction[31:22];
            dst_q     <= bus.instruction[21:12];
            if (bus.instruction[44]) begin
              state_q            <= StARd1;
              bus.memory_read    <= 1'b1;
              bus.memory_address <= bus.instruction[41:32];
              bus.alu_opcode     <= bus.instruction[43:42];
            end else if (bus.instruction[43:42] == 2'b01) begin
              state_q                   <= StWr;
              bus.memory_write          <= 1'b1;
              bus.memory_address        <= bus.instruction[41:32];
              bus.immediate_memory_data <= bus.instruction[31:0];
              bus.mux_select            <= 1'b0;
            end else if (bus.instruction[43:42] == 2'b00) begin
              state_q            <= StRd;
              bus.memory_read    <= 1'b1;
              bus.memory_address <= bus.instruction[41:32];
            end else begin
              // Reserved formats complete without touching memory.
              state_q <= StDone;
            end
          end
        end
        StRd: begin
          if (bus.mem_ready || timeout_hit) begin
            bus.memory_read <= 1'b0;
            state_q         <= StDone;
          end
        end
        StWr: begin
          if (bus.mem_ready || timeout_hit) begin
            bus.memory_write <= 1'b0;
            state_q          <= StDone;
          end
        end
        StARd1: begin
          if (bus.mem_ready) begin
            bus.memory_read     <= 1'b0;
            bus.reg_select      <= 1'b0;
            bus.reg_load_enable <= 1'b1;
            state_q             <= StALd1;
          end else if (timeout_hit) begin
            bus.memory_read <= 1'b0;
            bus.alu_opcode  <= '0;
            state_q         <= StDone;
          end
        end
        StALd1: begin
          bus.memory_read    <= 1'b1;
          bus.memory_address <= src2_q;
          state_q            <= StARd2;
        end
        StARd2: begin
          if (bus.mem_ready) begin
            bus.memory_read     <= 1'b0;
            bus.reg_select      <= 1'b1;
            bus.reg_load_enable <= 1'b1;
            state_q             <= StALd2;
          end else if (timeout_hit) begin
            bus.memory_read <= 1'b0;
            bus.alu_opcode  <= '0;
            state_q         <= StDone;
          end
        end
        StALd2: begin
          bus.memory_write   <= 1'b1;
          bus.mux_select     <= 1'b1;
          bus.memory_address <= dst_q;
          state_q            <= StAWr;
        end
        StAWr: begin
          if (bus.mem_ready || timeout_hit) begin
            bus.memory_write <= 1'b0;
            bus.mux_select   <= 1'b0;
            bus.alu_opcode   <= '0;
            state_q          <= StDone;
          end
        end
        StDone: begin
          bus.reg_select <= 1'b0;
          bus.ready      <= 1'b1;
          state_q        <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a behavioural word memory answers the strobes
// and pops expected accesses/loads from a scoreboard queue filled by the stimulus.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_unit_if ifc ();

  control_unit #(
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  localparam logic [1:0] EvRd  = 2'd0;
  localparam logic [1:0] EvWr  = 2'd1;
  localparam logic [1:0] EvLdA = 2'd2;
  localparam logic [1:0] EvLdB = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        mux;
    logic [1:0]  op;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] mem[1024];
  logic [31:0] data_out;
  int unsigned lat;
  int unsigned cnt;
  int unsigned strobe_cycles;
  int unsigned starts;
  int unsigned loads_seen;
  int unsigned n_tests;
  int unsigned n_fail;
  logic        prev_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [9:0] addr,
                         input logic [31:0] data, input logic mux, input logic [1:0] op);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.mux  = mux;
    e.op   = op;
    exp_q.push_back(e);
  endtask

  // Memory completes an access: compare against the scoreboard, then act on it.
  task automatic on_access();
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_access", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("acc_is_write", 32'(ifc.memory_write), 32'(e.kind == EvWr));
    check("acc_addr", 32'(ifc.memory_address), 32'(e.addr));
    check("acc_opcode", 32'(ifc.alu_opcode), 32'(e.op));
    if (ifc.memory_write) begin
      check("acc_mux", 32'(ifc.mux_select), 32'(e.mux));
      if (!ifc.mux_select) begin
        check("acc_wdata", ifc.immediate_memory_data, e.data);
        mem[ifc.memory_address] = ifc.immediate_memory_data;
      end else begin
        mem[ifc.memory_address] = 32'hC0DE_0000 | 32'(ifc.alu_opcode);
      end
    end else begin
      data_out = mem[ifc.memory_address];
      check("acc_rdata", data_out, e.data);
    end
  endtask

  task automatic on_load();
    ev_t e;
    loads_seen++;
    if (exp_q.size() == 0) begin
      check("unexpected_load", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ld_is_load", 32'(e.kind >= EvLdA), 32'd1);
    check("ld_reg_select", 32'(ifc.reg_select), 32'(e.kind == EvLdB));
    check("ld_data", data_out, e.data);
    check("ld_opcode", 32'(ifc.alu_opcode), 32'(e.op));
  endtask

  // Memory model and passive monitors, all sampled on the falling edge.
  initial begin
    ifc.mem_ready = 1'b0;
    cnt           = 0;
    prev_ready    = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        ifc.mem_ready = 1'b0;
        cnt           = 0;
      end else begin
        if (ifc.mem_ready) begin
          ifc.mem_ready = 1'b0;
          cnt           = 0;
        end else if (ifc.memory_read || ifc.memory_write) begin
          cnt++;
          if (cnt >= lat) begin
            ifc.mem_ready = 1'b1;
            cnt           = 0;
            on_access();
          end
        end else begin
          cnt = 0;
        end
        if (ifc.reg_load_enable) on_load();
        if (ifc.memory_read || ifc.memory_write) strobe_cycles++;
        if (prev_ready && !ifc.ready) starts++;
      end
      prev_ready = ifc.ready;
    end
  end

  task automatic start_instr(input logic [44:0] instr);
    int unsigned guard = 0;
    @(negedge clk);
    while (!ifc.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ifc.ready) check("ready_wait", 32'd0, 32'd1);
    ifc.instruction      = instr;
    ifc.operation_enable = 1'b1;
    @(negedge clk);
    ifc.operation_enable = 1'b0;
  endtask

  // Returns cycles counted from the enable cycle until ready is seen high again.
  task automatic run_instr(input logic [44:0] instr, output int unsigned cyc);
    start_instr(instr);
    cyc = 1;
    check("busy_after_start", 32'(ifc.ready), 32'd0);
    while (!ifc.ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!ifc.ready) check("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned guard;
    n_tests              = 0;
    n_fail               = 0;
    lat                  = 2;
    strobe_cycles        = 0;
    starts               = 0;
    loads_seen           = 0;
    data_out             = '0;
    ifc.instruction      = '0;
    ifc.operation_enable = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h5555_AAAA;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ifc.ready), 32'd1);
    check("rst_strobes", 32'({ifc.memory_read, ifc.memory_write, ifc.reg_load_enable,
                              ifc.mux_select, ifc.reg_select}), 32'd0);
    check("rst_opcode", 32'(ifc.alu_opcode), 32'd0);
    check("rst_addr", 32'(ifc.memory_address), 32'd0);
    check("rst_wdata", ifc.immediate_memory_data, 32'd0);
    rst = 1'b0;

    // Immediate write, then read it back.
    push_ev(EvWr, 10'h38A, 32'h1234_5678, 1'b0, 2'b00);
    run_instr({3'b001, 10'h38A, 32'h1234_5678}, cyc);
    check("wr_latency", cyc, lat + 2);
    push_ev(EvRd, 10'h38A, 32'h1234_5678, 1'b0, 2'b00);
    run_instr({3'b000, 10'h38A, 32'h0}, cyc);
    check("rd_latency", cyc, lat + 2);

    // ALU sequence: src1=0x000, src2=0x38A, dst=0x045, op=01.
    push_ev(EvRd, 10'h000, 32'h5555_AAAA, 1'b0, 2'b01);
    push_ev(EvLdA, 10'h000, 32'h5555_AAAA, 1'b0, 2'b01);
    push_ev(EvRd, 10'h38A, 32'h1234_5678, 1'b0, 2'b01);
    push_ev(EvLdB, 10'h38A, 32'h1234_5678, 1'b0, 2'b01);
    push_ev(EvWr, 10'h045, 32'h0, 1'b1, 2'b01);
    run_instr({1'b1, 2'b01, 10'h000, 10'h38A, 10'h045, 12'h0}, cyc);
    check("alu_latency", cyc, 3 * lat + 4);
    check("alu_under_20", 32'(cyc < 20), 32'd1);
    check("alu_dst_written", mem[10'h045], 32'hC0DE_0001);
    check("alu_opcode_idle", 32'(ifc.alu_opcode), 32'd0);

    // mem_ready arriving in the first strobe cycle.
    lat = 1;
    push_ev(EvRd, 10'h38A, 32'h1234_5678, 1'b0, 2'b00);
    run_instr({3'b000, 10'h38A, 32'h0}, cyc);
    check("rd_latency_fast", cyc, 3);
    lat = 2;

    // Top-of-memory boundary.
    push_ev(EvWr, 10'h3FF, 32'hFFFF_FFFF, 1'b0, 2'b00);
    run_instr({3'b001, 10'h3FF, 32'hFFFF_FFFF}, cyc);
    push_ev(EvRd, 10'h3FF, 32'hFFFF_FFFF, 1'b0, 2'b00);
    run_instr({3'b000, 10'h3FF, 32'h0}, cyc);

    // Reserved opcode with enable held high: one execution, no strobes.
    strobe_cycles = 0;
    starts        = 0;
    @(negedge clk);
    ifc.instruction      = {3'b010, 10'h12C, 32'hAAAA_5555};
    ifc.operation_enable = 1'b1;
    repeat (5) @(negedge clk);
    ifc.operation_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("held_en_ready", 32'(ifc.ready), 32'd1);
    check("held_en_starts", starts, 32'd1);
    check("reserved_strobes", strobe_cycles, 32'd0);
    run_instr({3'b011, 10'h001, 32'h1}, cyc);
    check("reserved_latency", cyc, 2);
    check("reserved_strobes2", strobe_cycles, 32'd0);

    // Reset during the second ALU read: abort, no write to dst.
    mem[10'h045] = 32'h0BAD_F00D;
    loads_seen   = 0;
    push_ev(EvRd, 10'h000, 32'h5555_AAAA, 1'b0, 2'b10);
    push_ev(EvLdA, 10'h000, 32'h5555_AAAA, 1'b0, 2'b10);
    push_ev(EvRd, 10'h38A, 32'h1234_5678, 1'b0, 2'b10);
    push_ev(EvLdB, 10'h38A, 32'h1234_5678, 1'b0, 2'b10);
    push_ev(EvWr, 10'h045, 32'h0, 1'b1, 2'b10);
    start_instr({1'b1, 2'b10, 10'h000, 10'h38A, 10'h045, 12'h0});
    guard = 0;
    while ((loads_seen == 0 || !ifc.memory_read) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("rd2_wait", 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_strobes", 32'({ifc.memory_read, ifc.memory_write, ifc.reg_load_enable,
                                ifc.mux_select, ifc.reg_select}), 32'd0);
    check("abort_ready", 32'(ifc.ready), 32'd1);
    check("abort_opcode", 32'(ifc.alu_opcode), 32'd0);
    check("abort_addr", 32'(ifc.memory_address), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_dst_write", mem[10'h045], 32'h0BAD_F00D);
    check("abort_idle_ready", 32'(ifc.ready), 32'd1);
    check("abort_idle_strobes", 32'({ifc.memory_read, ifc.memory_write}), 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
